// File: rtl/movavg_sequencer.sv
// movavg_sequencer: paces a valid/ready sample stream into a sum/shift moving averager,
// flushes it on start and captures each settled average. Rev 1.0
`default_nettype none

module movavg_sequencer #(
  parameter int DW           = 18,
  parameter int LOG2_SAMPLES = 8,
  parameter int DIVW         = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic [DIVW-1:0] cfg_div,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  output logic            ma_rst_n,
  output logic            ma_ena,
  output logic [DW-1:0]   ma_sample,
  input  logic [DW-1:0]   ma_avg,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            settled,
  output logic            underrun,
  output logic [15:0]     underrun_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FLUSH   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_STROBE  = 3'd3;
  localparam logic [2:0] S_SETTLE1 = 3'd4;
  localparam logic [2:0] S_SETTLE2 = 3'd5;
  localparam logic [2:0] S_CAPTURE = 3'd6;

  localparam int              CW         = LOG2_SAMPLES + 1;
  localparam logic [CW-1:0]   FULL_CNT   = {1'b1, {LOG2_SAMPLES{1'b0}}};
  localparam logic [DIVW-1:0] MIN_PERIOD = DIVW'(4);

  logic [2:0]      state_q, state_d;
  logic            flush_q, flush_d;
  logic [DIVW-1:0] period_q, period_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [CW-1:0]   strobe_cnt_q, strobe_cnt_d;
  logic            settled_q, settled_d;
  logic            underrun_q, underrun_d;
  logic [15:0]     ucnt_q, ucnt_d;
  logic [DW-1:0]   buf_q, buf_d;
  logic            buf_full_q, buf_full_d;
  logic            stop_pend_q, stop_pend_d;
  logic            ma_rst_n_q, ma_rst_n_d;
  logic            ma_ena_q, ma_ena_d;
  logic [DW-1:0]   ma_sample_q, ma_sample_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;

  logic w_run, w_tick, w_hs, w_stop, w_strobe;

  assign in_ready = !buf_full_q && (state_q != S_IDLE);
  assign w_hs     = in_valid && in_ready;
  assign w_stop   = stop_pend_q || stop;
  assign w_run    = (state_q != S_IDLE) && (state_q != S_FLUSH);
  // With the minimum period of 4 the tick can land on CAPTURE; it then chains straight into STROBE.
  assign w_tick   = ((state_q == S_WAIT) || (state_q == S_CAPTURE)) && (div_q == period_q - DIVW'(1));
  assign w_strobe = w_tick && (state_d == S_STROBE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_FLUSH;
      S_FLUSH:   if (flush_q) state_d = S_WAIT;
      S_WAIT:    if (w_tick) state_d = w_stop ? S_IDLE : S_STROBE;
      S_STROBE:  state_d = S_SETTLE1;
      S_SETTLE1: state_d = S_SETTLE2;
      S_SETTLE2: state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (w_stop)      state_d = S_IDLE;
        else if (w_tick) state_d = S_STROBE;
        else             state_d = S_WAIT;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    flush_d      = (state_q == S_FLUSH) ? !flush_q : 1'b0;
    period_d     = period_q;
    div_d        = div_q;
    strobe_cnt_d = strobe_cnt_q;
    settled_d    = settled_q;
    underrun_d   = 1'b0;
    ucnt_d       = ucnt_q;
    buf_d        = buf_q;
    buf_full_d   = buf_full_q;
    ma_sample_d  = ma_sample_q;
    ma_ena_d     = w_strobe;
    ma_rst_n_d   = (state_d != S_IDLE) && (state_d != S_FLUSH);
    out_valid_d  = (state_q == S_CAPTURE);
    out_data_d   = out_data_q;
    stop_pend_d  = ((state_q == S_IDLE) || (state_d == S_IDLE)) ? 1'b0 : (stop_pend_q || stop);

    if ((state_q == S_IDLE) && start) begin
      period_d     = (cfg_div < MIN_PERIOD) ? MIN_PERIOD : cfg_div;
      div_d        = '0;
      strobe_cnt_d = '0;
      settled_d    = 1'b0;
      ucnt_d       = '0;
    end

    if (w_run)
      div_d = (div_q == period_q - DIVW'(1)) ? '0 : div_q + DIVW'(1);

    if (state_q == S_IDLE) begin
      buf_full_d = 1'b0;
    end else if (w_strobe) begin
      if (buf_full_q) begin
        ma_sample_d = buf_q;
        buf_full_d  = 1'b0;
      end else if (w_hs) begin
        ma_sample_d = in_data;
      end else begin
        underrun_d = 1'b1;
        if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
      end
    end else if (w_hs) begin
      buf_d      = in_data;
      buf_full_d = 1'b1;
    end

    if (state_q == S_CAPTURE) begin
      out_data_d = ma_avg;
      if (strobe_cnt_q != FULL_CNT) strobe_cnt_d = strobe_cnt_q + CW'(1);
      settled_d = settled_q || (strobe_cnt_d == FULL_CNT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q      <= 1'b0;
      period_q     <= MIN_PERIOD;
      div_q        <= '0;
      strobe_cnt_q <= '0;
      settled_q    <= 1'b0;
      underrun_q   <= 1'b0;
      ucnt_q       <= '0;
      buf_q        <= '0;
      buf_full_q   <= 1'b0;
      stop_pend_q  <= 1'b0;
      ma_rst_n_q   <= 1'b0;
      ma_ena_q     <= 1'b0;
      ma_sample_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      flush_q      <= flush_d;
      period_q     <= period_d;
      div_q        <= div_d;
      strobe_cnt_q <= strobe_cnt_d;
      settled_q    <= settled_d;
      underrun_q   <= underrun_d;
      ucnt_q       <= ucnt_d;
      buf_q        <= buf_d;
      buf_full_q   <= buf_full_d;
      stop_pend_q  <= stop_pend_d;
      ma_rst_n_q   <= ma_rst_n_d;
      ma_ena_q     <= ma_ena_d;
      ma_sample_q  <= ma_sample_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  assign ma_rst_n     = ma_rst_n_q;
  assign ma_ena       = ma_ena_q;
  assign ma_sample    = ma_sample_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign settled      = settled_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = ucnt_q;

endmodule

`default_nettype wire

// File: tb/tb_movavg_sequencer.sv
// tb_movavg_sequencer: directed bench for movavg_sequencer; the averager is stood in for by
// ma_avg = ma_sample + 1 so every captured value is traceable to its strobe sample.
`default_nettype none

module tb_movavg_sequencer;
  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [15:0]   cfg_div = 16'd0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          ma_rst_n;
  logic          ma_ena;
  logic [DW-1:0] ma_sample;
  logic [DW-1:0] ma_avg;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          settled;
  logic          underrun;
  logic [15:0]   underrun_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int dbl = 0;
  logic ena_prev = 1'b0;

  assign ma_avg = ma_sample + 18'd1;

  movavg_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_div(cfg_div),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ma_rst_n(ma_rst_n), .ma_ena(ma_ena), .ma_sample(ma_sample), .ma_avg(ma_avg),
    .out_valid(out_valid), .out_data(out_data), .settled(settled),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (ma_ena && ena_prev) dbl++;
    ena_prev = ma_ena;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ena(output int c);
    int k = 0;
    @(negedge clk);
    while (!ma_ena && k < 200) begin @(negedge clk); k++; end
    check("ena_seen", {31'd0, ma_ena}, 32'd1);
    c = cyc;
  endtask

  task automatic wait_ov(output int c);
    int k = 0;
    @(negedge clk);
    while (!out_valid && k < 200) begin @(negedge clk); k++; end
    check("ov_seen", {31'd0, out_valid}, 32'd1);
    c = cyc;
  endtask

  task automatic pulse_start(input logic [15:0] div);
    cfg_div = div;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rstn"}, {31'd0, ma_rst_n}, 32'd0);
    check({tag, "_ena"}, {31'd0, ma_ena}, 32'd0);
    check({tag, "_sample"}, {14'd0, ma_sample}, 32'd0);
    check({tag, "_ov"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_od"}, {14'd0, out_data}, 32'd0);
    check({tag, "_settled"}, {31'd0, settled}, 32'd0);
    check({tag, "_ur"}, {31'd0, underrun}, 32'd0);
    check({tag, "_urcnt"}, {16'd0, underrun_cnt}, 32'd0);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    int c0, c1, prev, lat, k, enas;

    // power-on reset
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", {31'd0, in_ready}, 32'd0);

    // period 10, constant sample 100
    in_valid = 1'b1;
    in_data  = 18'd100;
    pulse_start(16'd10);
    wait_ena(c0);
    check("p10_sample", {14'd0, ma_sample}, 32'd100);
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    check("p10_latency", lat, 32'd4);
    check("p10_out", {14'd0, out_data}, 32'd101);
    for (int i = 0; i < 3; i++) begin
      wait_ena(c1);
      check("p10_gap", c1 - c0, 32'd10);
      c0 = c1;
    end
    check("p10_rstn", {31'd0, ma_rst_n}, 32'd1);

    // reset mid-run
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    @(negedge clk);

    // cfg_div=2 treated as period 4; settled on the 256th output
    dbl = 0;
    pulse_start(16'd2);
    wait_ov(prev);
    check("settled_1", {31'd0, settled}, 32'd0);
    for (int n = 2; n <= 256; n++) begin
      wait_ov(c1);
      check("p4_ov_gap", c1 - prev, 32'd4);
      check("settled", {31'd0, settled}, (n == 256) ? 32'd1 : 32'd0);
      prev = c1;
    end
    wait_ena(c0);
    for (int i = 0; i < 3; i++) begin
      wait_ena(c1);
      check("p4_ena_gap", c1 - c0, 32'd4);
      c0 = c1;
    end
    check("no_double_ena", dbl, 32'd0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    k = 0;
    while (ma_rst_n && k < 30) begin @(negedge clk); k++; end
    check("p4_stop_rstn", {31'd0, ma_rst_n}, 32'd0);
    check("p4_stop_ready", {31'd0, in_ready}, 32'd0);
    check("settled_hold", {31'd0, settled}, 32'd1);

    // underrun: sample 7 then three empty ticks
    in_data = 18'd7;
    in_valid = 1'b1;
    pulse_start(16'd10);
    check("start_clr_settled", {31'd0, settled}, 32'd0);
    wait_ena(c0);
    check("ur_first_sample", {14'd0, ma_sample}, 32'd7);
    check("ur_first_flag", {31'd0, underrun}, 32'd0);
    in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      wait_ena(c1);
      check("ur_sample_hold", {14'd0, ma_sample}, 32'd7);
      check("ur_pulse", {31'd0, underrun}, 32'd1);
      check("ur_count", {16'd0, underrun_cnt}, i);
    end
    @(negedge clk);
    check("ur_one_cycle", {31'd0, underrun}, 32'd0);

    // bypass: handshake exactly on the next tick edge with the buffer empty
    repeat (8) @(negedge clk);
    in_valid = 1'b1;
    in_data  = 18'h3FFFB;
    @(negedge clk);
    check("byp_ena", {31'd0, ma_ena}, 32'd1);
    check("byp_sample", {14'd0, ma_sample}, 32'h3FFFB);
    check("byp_no_ur", {31'd0, underrun}, 32'd0);
    check("byp_urcnt", {16'd0, underrun_cnt}, 32'd3);
    in_valid = 1'b0;

    // stop during SETTLE1: one more capture, then IDLE
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    check("stop_ov_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("stop_ov", {31'd0, out_valid}, 32'd1);
    check("stop_od", {14'd0, out_data}, 32'h3FFFC);
    check("stop_rstn", {31'd0, ma_rst_n}, 32'd0);
    check("stop_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    enas = 0;
    @(negedge clk);
    check("stop_ov_single", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (ma_ena || out_valid) enas++;
    end
    check("idle_quiet", enas, 32'd0);
    check("idle_ready2", {31'd0, in_ready}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
